// File: rtl/sid_voice_mix.sv
// rtl/sid_voice_mix.sv - three-voice waveform x envelope amplitude mixer with a shared bit-serial multiplier
module sid_voice_mix (
    input  logic        clk,
    input  logic        iRstN,
    input  logic        clkEn,
    input  logic [11:0] iWave0,
    input  logic [11:0] iWave1,
    input  logic [11:0] iWave2,
    input  logic [7:0]  iEnv0,
    input  logic [7:0]  iEnv1,
    input  logic [7:0]  iEnv2,
    input  logic [2:0]  iMute,
    output logic [15:0] oSample,
    output logic        oValid,
    output logic        oBusy,
    output logic        oOverrun
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_OUT  = 2'd2;

    logic [1:0]         state;
    logic [1:0]         voice;
    logic [2:0]         bit_idx;
    logic signed [21:0] acc;

    logic [11:0] wave0_sh, wave1_sh, wave2_sh;
    logic [7:0]  env0_sh, env1_sh, env2_sh;
    logic [2:0]  mute_sh;

    logic [11:0]        wave_cur;
    logic [7:0]         env_cur;
    logic               mute_cur;
    logic signed [11:0] s_cur;
    logic signed [21:0] addend;

    always_comb begin
        wave_cur = wave0_sh;
        env_cur  = env0_sh;
        mute_cur = mute_sh[0];
        case (voice)
            2'd1: begin
                wave_cur = wave1_sh;
                env_cur  = env1_sh;
                mute_cur = mute_sh[1];
            end
            2'd2: begin
                wave_cur = wave2_sh;
                env_cur  = env2_sh;
                mute_cur = mute_sh[2];
            end
            default: ;
        endcase
    end

    // Offset-binary to two's complement: flipping the MSB subtracts the 0x800 midpoint.
    assign s_cur = {~wave_cur[11], wave_cur[10:0]};

    always_comb begin
        addend = '0;
        if (env_cur[bit_idx] && !mute_cur)
            addend = {{10{s_cur[11]}}, s_cur} <<< bit_idx;
    end

    assign oBusy = (state != ST_IDLE);

    always_ff @(posedge clk or negedge iRstN) begin
        if (!iRstN) begin
            state    <= ST_IDLE;
            voice    <= '0;
            bit_idx  <= '0;
            acc      <= '0;
            wave0_sh <= '0;
            wave1_sh <= '0;
            wave2_sh <= '0;
            env0_sh  <= '0;
            env1_sh  <= '0;
            env2_sh  <= '0;
            mute_sh  <= '0;
            oSample  <= '0;
            oValid   <= 1'b0;
            oOverrun <= 1'b0;
        end else begin
            oValid <= 1'b0;
            if (clkEn && state != ST_IDLE)
                oOverrun <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (clkEn) begin
                        wave0_sh <= iWave0;
                        wave1_sh <= iWave1;
                        wave2_sh <= iWave2;
                        env0_sh  <= iEnv0;
                        env1_sh  <= iEnv1;
                        env2_sh  <= iEnv2;
                        mute_sh  <= iMute;
                        acc      <= '0;
                        voice    <= '0;
                        bit_idx  <= '0;
                        state    <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    acc     <= acc + addend;
                    bit_idx <= bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        if (voice == 2'd2)
                            state <= ST_OUT;
                        else
                            voice <= voice + 2'd1;
                    end
                end
                ST_OUT: begin
                    oSample <= acc[21:6];
                    oValid  <= 1'b1;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
